// File: rtl/result_checker_if.sv
// result_checker_if
//   Groups the run-control, FIFO handshake and status signals of the result
//   checker. clock/reset stay plain module ports.
//   modport master : the checker side (drives read/write requests and status).
//   modport slave  : the surrounding logic (FIFOs and run controller).
//   Signals: start, num_vectors, rfifo_*, efifo_*, lfifo_*, busy, done,
//            vec_count, fail_count.
interface result_checker_if #(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16
);
  localparam int LOG_WIDTH = CNT_WIDTH + 2*RTF_WIDTH;

  logic                   start;
  logic [CNT_WIDTH-1:0]   num_vectors;
  logic [RTF_WIDTH-1:0]   rfifo_data;
  logic                   rfifo_rdreq;
  logic                   rfifo_rdempty;
  logic [2*RTF_WIDTH-1:0] efifo_data;
  logic                   efifo_rdreq;
  logic                   efifo_rdempty;
  logic [LOG_WIDTH-1:0]   lfifo_data;
  logic                   lfifo_wrreq;
  logic                   lfifo_wrfull;
  logic                   busy;
  logic                   done;
  logic [CNT_WIDTH-1:0]   vec_count;
  logic [CNT_WIDTH-1:0]   fail_count;

  modport master (
    input  start, num_vectors, rfifo_data, rfifo_rdempty,
           efifo_data, efifo_rdempty, lfifo_wrfull,
    output rfifo_rdreq, efifo_rdreq, lfifo_data, lfifo_wrreq,
           busy, done, vec_count, fail_count
  );

  modport slave (
    output start, num_vectors, rfifo_data, rfifo_rdempty,
           efifo_data, efifo_rdempty, lfifo_wrfull,
    input  rfifo_rdreq, efifo_rdreq, lfifo_data, lfifo_wrreq,
           busy, done, vec_count, fail_count
  );
endinterface

// File: rtl/result_checker.sv
// result_checker
//   Drains the RES_FIFO and EXP_FIFO in lock-step, compares each result with
//   its expected word under a don't-care mask, counts vectors and failures,
//   and writes a {vector_index, result, diff} record to the LOG_FIFO for every
//   failing vector. One run of num_vectors vectors per start pulse.
//   Ports: clock, reset (async, active-high), bus (result_checker_if.master).
//   Optional build macro RESULT_CHECKER_STOP_ON_FAIL_EN: end the run right
//   after the first failure record has been written.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   FETCH   | waiting for both FIFOs non-empty, then read one entry of each
//   COMPARE | read data valid: compare, register log record, update counters
//   LOG     | write failure record, stalls while LOG_FIFO is full
//   DONE    | run complete, waiting for start
module result_checker #(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  result_checker_if.master bus
);
  localparam int LOG_WIDTH = CNT_WIDTH + 2*RTF_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_COMPARE,
    S_LOG,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_WIDTH-1:0] r_num_vec;
  logic [CNT_WIDTH-1:0] r_vec_count;
  logic [CNT_WIDTH-1:0] r_fail_count;
  logic [LOG_WIDTH-1:0] r_lfifo_data;

  logic [RTF_WIDTH-1:0] w_expected;
  logic [RTF_WIDTH-1:0] w_mask;
  logic [RTF_WIDTH-1:0] w_diff;
  logic [CNT_WIDTH-1:0] w_vec_inc;
  logic                 w_fifos_ready;
  logic                 w_fail;
  logic                 w_last_cmp;
  logic                 w_last_log;
  logic                 w_idle_start;
  logic                 w_rdreq;
  logic                 w_wrreq;
  logic                 w_busy;
  logic                 w_done;

  assign w_expected    = bus.efifo_data[RTF_WIDTH-1:0];
  assign w_mask        = bus.efifo_data[2*RTF_WIDTH-1:RTF_WIDTH];
  assign w_diff        = (bus.rfifo_data ^ w_expected) & w_mask;
  assign w_fail        = |w_diff;
  assign w_vec_inc     = r_vec_count + 1'b1;
  assign w_fifos_ready = ~bus.rfifo_rdempty & ~bus.efifo_rdempty;
  // In COMPARE the counter has not yet advanced; in LOG it already has.
  assign w_last_cmp    = (w_vec_inc == r_num_vec);
  assign w_last_log    = (r_vec_count == r_num_vec);
  assign w_idle_start  = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next = (bus.num_vectors == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_fifos_ready) begin
          w_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (w_fail) begin
          w_next = S_LOG;
        end else if (w_last_cmp) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_LOG: begin
        if (!bus.lfifo_wrfull) begin
`ifdef RESULT_CHECKER_STOP_ON_FAIL_EN
          w_next = S_DONE;
`else
          w_next = w_last_log ? S_DONE : S_FETCH;
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdreq = (r_state == S_FETCH) && w_fifos_ready;
    w_wrreq = (r_state == S_LOG) && !bus.lfifo_wrfull;
    w_busy  = (r_state == S_FETCH) || (r_state == S_COMPARE) || (r_state == S_LOG);
    w_done  = (r_state == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_num_vec    <= '0;
      r_vec_count  <= '0;
      r_fail_count <= '0;
      r_lfifo_data <= '0;
    end else if (w_idle_start) begin
      r_num_vec    <= bus.num_vectors;
      r_vec_count  <= '0;
      r_fail_count <= '0;
    end else if (r_state == S_COMPARE) begin
      r_lfifo_data <= {r_vec_count, bus.rfifo_data, w_diff};
      r_vec_count  <= w_vec_inc;
      if (w_fail && (r_fail_count != '1)) begin
        r_fail_count <= r_fail_count + 1'b1;
      end
    end
  end

  assign bus.rfifo_rdreq = w_rdreq;
  assign bus.efifo_rdreq = w_rdreq;
  assign bus.lfifo_wrreq = w_wrreq;
  assign bus.lfifo_data  = r_lfifo_data;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.vec_count   = r_vec_count;
  assign bus.fail_count  = r_fail_count;
endmodule

// File: tb/tb_result_checker.sv
module tb_result_checker;
  localparam int RW    = 24;
  localparam int CW    = 16;
  localparam int LW    = CW + 2*RW;
  localparam int MEMSZ = 2048;

  logic clock = 1'b0;
  logic reset = 1'b1;

  result_checker_if #(.RTF_WIDTH(RW), .CNT_WIDTH(CW)) bus ();
  result_checker #(.RTF_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // FIFO models: memory plus free-running write/read indices
  logic [RW-1:0]   res_mem [MEMSZ];
  logic [2*RW-1:0] exp_mem [MEMSZ];
  int res_wr = 0, res_rd = 0, exp_wr = 0, exp_rd = 0;
  int rd_events = 0, wr_events = 0;
  logic [LW-1:0] last_log = '0;
  logic force_r = 1'b0, force_e = 1'b0;
  bit   rand_mode = 1'b0;

  int n_cmp = 0, n_fail = 0;

  // reference model state
  logic [LW-1:0] exp_log [$];
  logic [RW-1:0] pv_r [$], pv_e [$], pv_m [$];
  int exp_vec, exp_fail, exp_nlog, run_n, run_wr0, last_rem;

  assign bus.rfifo_rdempty = (res_rd >= res_wr) || force_r;
  assign bus.efifo_rdempty = (exp_rd >= exp_wr) || force_e;

  always @(posedge clock) begin
    if (bus.rfifo_rdreq) begin
      bus.rfifo_data <= res_mem[res_rd % MEMSZ];
      res_rd         <= res_rd + 1;
      rd_events      <= rd_events + 1;
    end
    if (bus.efifo_rdreq) begin
      bus.efifo_data <= exp_mem[exp_rd % MEMSZ];
      exp_rd         <= exp_rd + 1;
    end
    if (bus.lfifo_wrreq) begin
      last_log  <= bus.lfifo_data;
      wr_events <= wr_events + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // per-cycle compare process
  always @(negedge clock) begin
    if (!reset) begin
      chk("rdreq_pair", 64'(bus.rfifo_rdreq), 64'(bus.efifo_rdreq));
      if (bus.rfifo_rdreq || bus.efifo_rdreq)
        chk("rd_when_empty", 64'(bus.rfifo_rdempty | bus.efifo_rdempty), 64'd0);
      if (bus.lfifo_wrreq) begin
        chk("wr_when_full", 64'(bus.lfifo_wrfull), 64'd0);
        if (exp_log.size() > 0) begin
          chk("log_record", 64'(bus.lfifo_data), 64'(exp_log.pop_front()));
        end else begin
          n_cmp++;
          n_fail++;
          $display("FAIL log_unexpected actual=%0h required=none", bus.lfifo_data);
        end
      end
      chk("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_mode) begin
      force_r          = ($urandom_range(0, 3) == 0);
      force_e          = ($urandom_range(0, 3) == 0);
      bus.lfifo_wrfull = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic add_vec(input logic [RW-1:0] r, input logic [RW-1:0] e, input logic [RW-1:0] m);
    res_mem[res_wr % MEMSZ] = r;
    exp_mem[exp_wr % MEMSZ] = {m, e};
    res_wr++;
    exp_wr++;
    pv_r.push_back(r);
    pv_e.push_back(e);
    pv_m.push_back(m);
  endtask

  // Expected outcome of a run straight from the checking rules.
  task automatic model_run();
    logic [RW-1:0] d;
    exp_vec  = 0;
    exp_fail = 0;
    exp_nlog = 0;
    for (int i = 0; i < pv_r.size(); i++) begin
      d = (pv_r[i] ^ pv_e[i]) & pv_m[i];
      exp_vec++;
      if (d != '0) begin
        exp_fail++;
        exp_nlog++;
        exp_log.push_back({CW'(i), pv_r[i], d});
`ifdef RESULT_CHECKER_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    pv_r.delete();
    pv_e.delete();
    pv_m.delete();
  endtask

  task automatic begin_run();
    run_n   = pv_r.size();
    run_wr0 = wr_events;
    model_run();
    bus.num_vectors = CW'(run_n);
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if (bus.done) begin
        cycles = c;
        break;
      end
    end
    if (cycles < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout actual=no_done required=done_within_%0d", tag, budget);
    end
  endtask

  task automatic wait_fail(input string tag, input int budget);
    int ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (bus.fail_count != '0) begin
        ok = 1;
        break;
      end
      step();
    end
    if (ok == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_failwait actual=no_fail required=fail_within_%0d", tag, budget);
    end
  endtask

  task automatic end_run(input string tag, input int budget, output int cycles);
    wait_done(tag, budget, cycles);
    rand_mode        = 1'b0;
    force_r          = 1'b0;
    force_e          = 1'b0;
    bus.lfifo_wrfull = 1'b0;
    chk({tag, "_vec"},   64'(bus.vec_count),  64'(exp_vec));
    chk({tag, "_fail"},  64'(bus.fail_count), 64'(exp_fail));
    chk({tag, "_done"},  64'(bus.done),       64'd1);
    chk({tag, "_nlog"},  64'(wr_events - run_wr0), 64'(exp_nlog));
    chk({tag, "_logq"},  64'(exp_log.size()), 64'd0);
    chk({tag, "_rrem"},  64'(res_wr - res_rd), 64'(run_n - exp_vec));
    chk({tag, "_erem"},  64'(exp_wr - exp_rd), 64'(run_n - exp_vec));
    last_rem = res_wr - res_rd;
    res_wr   = res_rd;
    exp_wr   = exp_rd;
    exp_log.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rrd"},  64'(bus.rfifo_rdreq), 64'd0);
    chk({tag, "_erd"},  64'(bus.efifo_rdreq), 64'd0);
    chk({tag, "_wr"},   64'(bus.lfifo_wrreq), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy),        64'd0);
    chk({tag, "_done"}, 64'(bus.done),        64'd0);
    chk({tag, "_ldat"}, 64'(bus.lfifo_data),  64'd0);
    chk({tag, "_vec"},  64'(bus.vec_count),   64'd0);
    chk({tag, "_fail"}, 64'(bus.fail_count),  64'd0);
  endtask

  initial begin
    int cyc, rd0, w0, n, kind;
    logic [RW-1:0] r, e, m;

    bus.start        = 1'b0;
    bus.num_vectors  = '0;
    bus.lfifo_wrfull = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    // zero-length run
    chk("zero_pre_done", 64'(bus.done), 64'd0);
    begin_run();
    chk("zero_done_1cyc", 64'(bus.done), 64'd1);
    chk("zero_busy", 64'(bus.busy), 64'd0);
    end_run("zero", 5, cyc);

    // all pass: two cycles per vector
    for (int i = 1; i <= 4; i++) add_vec(RW'(i), RW'(i), 24'hFFFFFF);
    begin_run();
    end_run("allpass", 100, cyc);
    chk("allpass_cycles", 64'(cyc), 64'd8);
    chk("allpass_vec_lit", 64'(bus.vec_count), 64'd4);
    chk("allpass_ldat_lit", 64'(bus.lfifo_data), 64'h0003_000004_000000);

    // masked bits pass, then same vector fully compared fails
    add_vec(24'h00FF00, 24'h000000, 24'hFF00FF);
    begin_run();
    end_run("masked_pass", 50, cyc);
    chk("masked_pass_fail_lit", 64'(bus.fail_count), 64'd0);
    add_vec(24'h00FF00, 24'h000000, 24'hFFFFFF);
    begin_run();
    end_run("masked_fail", 50, cyc);
    chk("masked_fail_cycles", 64'(cyc), 64'd3);
    chk("masked_fail_log_lit", 64'(last_log), 64'h0000_00FF00_00FF00);
    chk("masked_fail_cnt_lit", 64'(bus.fail_count), 64'd1);

    // log backpressure on vector index 1
    add_vec(24'h111111, 24'h111111, 24'hFFFFFF);
    add_vec(24'h222222, 24'h222223, 24'hFFFFFF);
    add_vec(24'h333333, 24'h333333, 24'hFFFFFF);
    bus.lfifo_wrfull = 1'b1;
    begin_run();
    wait_fail("bp", 50);
    rd0 = rd_events;
    w0  = wr_events;
    repeat (5) step();
    chk("bp_no_reads", 64'(rd_events - rd0), 64'd0);
    chk("bp_no_writes", 64'(wr_events - w0), 64'd0);
    chk("bp_busy", 64'(bus.busy), 64'd1);
    chk("bp_vec_stall", 64'(bus.vec_count), 64'd2);
    bus.lfifo_wrfull = 1'b0;
    end_run("bp", 100, cyc);
    chk("bp_one_write_lit", 64'(wr_events - w0), 64'd1);
    chk("bp_vec_lit", 64'(bus.vec_count), 64'd3);

    // EXP_FIFO empty stall
    add_vec(24'h0A0A0A, 24'h0A0A0A, 24'hFFFFFF);
    add_vec(24'h0B0B0B, 24'h0B0B0B, 24'hFFFFFF);
    force_e = 1'b1;
    begin_run();
    rd0 = rd_events;
    repeat (10) step();
    chk("stall_no_reads", 64'(rd_events - rd0), 64'd0);
    chk("stall_busy", 64'(bus.busy), 64'd1);
    force_e = 1'b0;
    end_run("stall", 100, cyc);

    // reset while stalled in LOG
    add_vec(24'h0000F0, 24'h00000F, 24'hFFFFFF);
    add_vec(24'h000001, 24'h000001, 24'hFFFFFF);
    add_vec(24'h000002, 24'h000002, 24'hFFFFFF);
    bus.lfifo_wrfull = 1'b1;
    begin_run();
    wait_fail("rst", 50);
    step();
    step();
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    exp_log.delete();
    res_wr = res_rd;
    exp_wr = exp_rd;
    bus.lfifo_wrfull = 1'b0;
    step();
    reset = 1'b0;
    step();
    add_vec(24'h123456, 24'h123456, 24'hFFFFFF);
    add_vec(24'h654321, 24'h000000, 24'h0000FF);
    begin_run();
    end_run("after_reset", 100, cyc);

    // five vectors, index 1 fails
    add_vec(24'h000010, 24'h000010, 24'hFFFFFF);
    add_vec(24'h000020, 24'h000021, 24'hFFFFFF);
    add_vec(24'h000030, 24'h000030, 24'hFFFFFF);
    add_vec(24'h000040, 24'h000040, 24'hFFFFFF);
    add_vec(24'h000050, 24'h000050, 24'hFFFFFF);
    begin_run();
    end_run("five", 100, cyc);
`ifdef RESULT_CHECKER_STOP_ON_FAIL_EN
    chk("stop_vec_lit", 64'(bus.vec_count), 64'd2);
    chk("stop_rem_lit", 64'(last_rem), 64'd3);
`else
    chk("five_vec_lit", 64'(bus.vec_count), 64'd5);
    chk("five_rem_lit", 64'(last_rem), 64'd0);
`endif

    // randomized runs with random FIFO stalls and log backpressure
    for (int run = 0; run < 25; run++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        r    = RW'($urandom);
        kind = $urandom_range(0, 2);
        case (kind)
          0:       begin e = r;                m = RW'($urandom); end
          1:       begin e = RW'($urandom);    m = 24'hFFFFFF;    end
          default: begin e = r ^ RW'($urandom); m = RW'($urandom); end
        endcase
        add_vec(r, e, m);
      end
      begin_run();
      rand_mode = 1'b1;
      end_run("rand", 3000, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
